// File: rtl/score_display_controller.sv
// Two-player score keeper with round-robin point arbitration and a registered
// 7-segment decode; the winning digit blinks once the game is over.
module score_display_controller #(
   parameter int WIN_SCORE = 9,
   parameter int BLINK_CNT = 12500000
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Score_P1,
   input  logic       i_Score_P2,
   input  logic       i_Game_Reset,
   output logic [6:0] o_Segment1,
   output logic [6:0] o_Segment2,
   output logic       o_Game_Over,
   output logic       o_Winner,
   output logic       o_Fsm_State
);

   localparam logic [0:0] PLAY = 1'b0;
   localparam logic [0:0] OVER = 1'b1;

   localparam int               CNT_W     = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_CNT - 1);
   localparam logic [3:0]       WIN_VAL   = 4'(WIN_SCORE);
   localparam logic [6:0]       SEG_BLANK = 7'b1111111;
   localparam logic [6:0]       SEG_ZERO  = 7'b0000001;

   logic [0:0]       r_State;
   logic [3:0]       r_Score1;
   logic [3:0]       r_Score2;
   logic             r_Pend_1;
   logic             r_Pend_2;
   logic             r_Favour_P2;
   logic [CNT_W-1:0] r_Blink_Cnt;
   logic             r_Blank;
   logic             r_Winner;

   logic w_Won;
   logic w_Arb;
   logic w_Req_1;
   logic w_Req_2;
   logic w_Grant_1;
   logic w_Grant_2;
   logic w_Blank_1;
   logic w_Blank_2;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'd0:    seg_decode = 7'b0000001;
         4'd1:    seg_decode = 7'b1001111;
         4'd2:    seg_decode = 7'b0010010;
         4'd3:    seg_decode = 7'b0000110;
         4'd4:    seg_decode = 7'b1001100;
         4'd5:    seg_decode = 7'b0100100;
         4'd6:    seg_decode = 7'b0100000;
         4'd7:    seg_decode = 7'b0001111;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0000100;
         default: seg_decode = SEG_BLANK;
      endcase
   endfunction

   // Once a score sits at WIN_SCORE no further grants happen; the next edge
   // moves to OVER, so scores can never pass WIN_SCORE.
   assign w_Won   = (r_Score1 == WIN_VAL) || (r_Score2 == WIN_VAL);
   assign w_Arb   = (r_State == PLAY) && !w_Won;
   assign w_Req_1 = w_Arb && (i_Score_P1 || r_Pend_1);
   assign w_Req_2 = w_Arb && (i_Score_P2 || r_Pend_2);

   // The round-robin pointer only moves when both players contend.
   always_comb begin
      w_Grant_1 = 1'b0;
      w_Grant_2 = 1'b0;
      if (w_Req_1 && w_Req_2) begin
         w_Grant_1 = !r_Favour_P2;
         w_Grant_2 = r_Favour_P2;
      end else begin
         w_Grant_1 = w_Req_1;
         w_Grant_2 = w_Req_2;
      end
   end

   assign w_Blank_1 = (r_State == OVER) && r_Blank && !r_Winner;
   assign w_Blank_2 = (r_State == OVER) && r_Blank && r_Winner;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_State     <= PLAY;
         r_Score1    <= 4'd0;
         r_Score2    <= 4'd0;
         r_Pend_1    <= 1'b0;
         r_Pend_2    <= 1'b0;
         r_Favour_P2 <= 1'b0;
         r_Blink_Cnt <= '0;
         r_Blank     <= 1'b0;
         r_Winner    <= 1'b0;
         o_Segment1  <= SEG_ZERO;
         o_Segment2  <= SEG_ZERO;
      end else begin
         o_Segment1 <= w_Blank_1 ? SEG_BLANK : seg_decode(r_Score1);
         o_Segment2 <= w_Blank_2 ? SEG_BLANK : seg_decode(r_Score2);
         if (i_Game_Reset) begin
            r_State     <= PLAY;
            r_Score1    <= 4'd0;
            r_Score2    <= 4'd0;
            r_Pend_1    <= 1'b0;
            r_Pend_2    <= 1'b0;
            r_Favour_P2 <= 1'b0;
            r_Blink_Cnt <= '0;
            r_Blank     <= 1'b0;
            r_Winner    <= 1'b0;
         end else begin
            case (r_State)
               PLAY: begin
                  if (w_Won) begin
                     r_State     <= OVER;
                     r_Winner    <= (r_Score2 == WIN_VAL);
                     r_Blink_Cnt <= '0;
                     r_Blank     <= 1'b0;
                     r_Pend_1    <= 1'b0;
                     r_Pend_2    <= 1'b0;
                  end else begin
                     if (w_Grant_1) r_Score1 <= r_Score1 + 4'd1;
                     if (w_Grant_2) r_Score2 <= r_Score2 + 4'd1;
                     r_Pend_1 <= w_Req_1 && !w_Grant_1;
                     r_Pend_2 <= w_Req_2 && !w_Grant_2;
                     if (w_Req_1 && w_Req_2) r_Favour_P2 <= !r_Favour_P2;
                  end
               end
               OVER: begin
                  r_Pend_1 <= 1'b0;
                  r_Pend_2 <= 1'b0;
                  if (r_Blink_Cnt == CNT_LAST) begin
                     r_Blink_Cnt <= '0;
                     r_Blank     <= !r_Blank;
                  end else begin
                     r_Blink_Cnt <= r_Blink_Cnt + 1'b1;
                  end
               end
               default: r_State <= PLAY;
            endcase
         end
      end
   end

   assign o_Game_Over = (r_State == OVER);
   assign o_Winner    = r_Winner;
   assign o_Fsm_State = r_State;

endmodule

// File: tb/tb_score_display_controller.sv
// Scoreboard bench for score_display_controller: a per-edge game model pushes
// expected display state, a negedge monitor pops and compares.
module tb_score_display_controller;

   localparam int WIN   = 3;
   localparam int BLINK = 4;
   localparam int W     = 16;
   localparam logic [6:0] ZERO  = 7'b0000001;
   localparam logic [6:0] BLANK = 7'b1111111;

   logic       i_Clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       p1 = 1'b0;
   logic       p2 = 1'b0;
   logic       gr = 1'b0;
   logic [6:0] seg1;
   logic [6:0] seg2;
   logic       game_over;
   logic       winner;
   logic       fsm_state;

   always #5 i_Clk = ~i_Clk;

   score_display_controller #(.WIN_SCORE(WIN), .BLINK_CNT(BLINK)) dut (
      .i_Clk        (i_Clk),
      .i_Rst_L      (rst_n),
      .i_Score_P1   (p1),
      .i_Score_P2   (p2),
      .i_Game_Reset (gr),
      .o_Segment1   (seg1),
      .o_Segment2   (seg2),
      .o_Game_Over  (game_over),
      .o_Winner     (winner),
      .o_Fsm_State  (fsm_state)
   );

   logic [6:0] lut [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   // game model: scores, pending requests, contention favourite, game-over and
   // number of edges spent in OVER (drives the blink phase)
   int m_score [2];
   bit m_pend  [2];
   int m_fav;
   bit m_over;
   bit m_winner;
   int m_k;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic void model_clear();
      m_score[0] = 0; m_score[1] = 0;
      m_pend[0]  = 0; m_pend[1]  = 0;
      m_fav = 0; m_over = 0; m_winner = 0; m_k = 0;
   endfunction

   function automatic logic [6:0] seg_of(input int p);
      if (m_over && (int'(m_winner) == p) && (((m_k / BLINK) % 2) == 1)) return BLANK;
      return lut[m_score[p]];
   endfunction

   function automatic void model_step(input bit a, input bit b, input bit g);
      bit r0, r1;
      int gi;
      gi = -1;
      if (g) model_clear();
      else if (m_over) begin
         m_k++;
         m_pend[0] = 0; m_pend[1] = 0;
      end else if (m_score[0] == WIN || m_score[1] == WIN) begin
         m_over = 1; m_winner = (m_score[1] == WIN); m_k = 0;
         m_pend[0] = 0; m_pend[1] = 0;
      end else begin
         r0 = a | m_pend[0];
         r1 = b | m_pend[1];
         if (r0 && r1) begin
            gi = m_fav;
            m_pend[m_fav] = 0;
            m_pend[1 - m_fav] = 1;
            m_fav = 1 - m_fav;
         end else if (r0) begin
            gi = 0; m_pend[0] = 0;
         end else if (r1) begin
            gi = 1; m_pend[1] = 0;
         end
         if (gi >= 0) m_score[gi]++;
      end
   endfunction

   // one clock: inputs driven after negedge, reset may drop mid-cycle
   task automatic tick(input bit a, input bit b, input bit g, input bit r);
      logic [W-1:0] e;
      @(negedge i_Clk);
      #1;
      p1 = a; p2 = b; gr = g;
      if (!r && rst_n) begin
         #1 rst_n = 1'b0;
         #1 check("async_reset", {game_over, winner, seg1, seg2}, {2'b00, ZERO, ZERO});
      end else begin
         rst_n = r;
      end
      @(posedge i_Clk);
      if (!r) begin
         model_clear();
         e = {2'b00, ZERO, ZERO};
      end else begin
         e[13:7] = seg_of(0);
         e[6:0]  = seg_of(1);
         model_step(a, b, g);
         e[15] = m_over;
         e[14] = m_winner;
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 1);
   endtask

   initial begin : monitor
      logic [W-1:0] e;
      logic [W-1:0] a;
      forever begin
         @(negedge i_Clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {game_over, winner, seg1, seg2};
            if (!e[15]) a[14] = 1'b0;
            check("outputs", a, e);
         end
      end
   end

   initial begin : driver
      model_clear();
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      // single P1 point
      tick(1, 0, 0, 1);
      idle(3);
      tick(0, 0, 1, 1);
      // P2 wins with three spaced points, then blinks
      for (int i = 0; i < 3; i++) begin
         tick(0, 1, 0, 1);
         idle(1);
      end
      idle(16);
      tick(1, 0, 0, 1);
      idle(2);
      tick(0, 0, 1, 1);
      idle(2);
      // simultaneous pairs alternate the favourite
      tick(1, 1, 0, 1);
      idle(2);
      tick(1, 1, 0, 1);
      idle(2);
      tick(0, 0, 1, 1);
      // reach 2-2 with P1 pending, then async reset
      tick(1, 1, 0, 1);
      idle(1);
      tick(1, 0, 0, 1);
      tick(1, 1, 0, 1);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      idle(4);
      // game reset beats a same-cycle point
      tick(1, 0, 1, 1);
      idle(2);
      // P1 wins a game
      for (int i = 0; i < 3; i++) begin
         tick(1, 0, 0, 1);
         idle(1);
      end
      idle(10);
      // randomized play
      for (int i = 0; i < 500; i++) begin
         tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 79) != 0);
      end
      idle(2);
      @(negedge i_Clk);
      #1;
      check("queue_drained", W'(exp_q.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
      $fatal(1);
   end

endmodule

// File: doc/score_display_controller.md
SCORE_DISPLAY_CONTROLLER -- requirements
Module: score_display_controller

Interface
REQ-001 Parameter WIN_SCORE, default 9, is the score (1..9) at which a player wins.
REQ-002 Parameter BLINK_CNT, default 12500000, is the number of clocks per blink half-period (0.5 s at 25 MHz).
REQ-003 i_Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 i_Rst_L  input  1  reset, asynchronous and active-low.
REQ-005 i_Score_P1  input  1  single-cycle point request for player 1 (debounced/edge-detected upstream).
REQ-006 i_Score_P2  input  1  single-cycle point request for player 2.
REQ-007 i_Game_Reset  input  1  synchronous request to clear both scores and restart play.
REQ-008 o_Segment1  output  7  player-1 digit, active-low, bit6=A through bit0=G.
REQ-009 o_Segment2  output  7  player-2 digit, same encoding.
REQ-010 o_Game_Over  output  1  high while in state OVER.
REQ-011 o_Winner  output  1  0 = player 1 won, 1 = player 2 won; valid only while o_Game_Over=1.

Function
REQ-012 The module SHALL hold two 4-bit scores, r_Score1 and r_Score2, each in the range 0..WIN_SCORE, with no wrap-around.
REQ-013 FSM states SHALL be PLAY and OVER.
- PLAY -> OVER on the cycle after a granted increment makes either score equal WIN_SCORE.
- OVER -> PLAY on i_Game_Reset.
REQ-014 Request for player n = (i_Score_Pn | r_Pend_n), evaluated in PLAY only.
REQ-015 At most one score SHALL increment per cycle.
- If exactly one request is present, grant it.
- If both are present, grant the player not granted most recently; the round-robin pointer resets to favour P1.
REQ-016 An ungranted request SHALL set its r_Pend_n bit; a granted request SHALL clear it.
- A new pulse arriving while r_Pend_n=1 and not granted is absorbed; it is not double-counted.
REQ-017 Latency: a request granted in cycle N updates the score register at edge N+1, and the segment outputs at edge N+2 (registered decode).
REQ-018 In OVER, score pulses SHALL be ignored, both pending bits SHALL be cleared, and scores SHALL be frozen.
REQ-019 On entry to OVER:
- o_Winner = the player whose score equals WIN_SCORE.
- The blink counter is set to 0 and the blink phase to "shown".
REQ-020 In OVER, the blink counter SHALL count 0..BLINK_CNT-1.
- At terminal count it wraps to 0 and toggles the phase.
- The winner digit shows its score in phase "shown" and is blank (7'b1111111) in phase "blank".
- The loser digit stays steady.
REQ-021 i_Game_Reset in any state SHALL clear both scores, both pending bits, the blink state and the pointer, and enter PLAY.
- It has priority over same-cycle score pulses, which are discarded.
REQ-022 Decode (active-low, A..G), digits 0-9:
- 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
- 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
REQ-023 Any score value above 9 SHALL decode to blank (unreachable by construction).

Reset
REQ-024 While i_Rst_L=0, the module SHALL force immediately:
- scores 0, pending bits 0, pointer favouring P1, state PLAY, blink counter 0, phase "shown"
- o_Game_Over=0, o_Winner=0, o_Segment1=o_Segment2=7'b0000001 ("0")
REQ-025 Reset asserted mid-game or mid-blink SHALL abandon all state with no residual pending increment after release.
REQ-026 Operation SHALL resume on the first rising edge of i_Clk after i_Rst_L deasserts.

Verification (WIN_SCORE=3, BLINK_CNT=4)
REQ-027 Reset release, then one i_Score_P1 pulse -> two edges later o_Segment1=7'b1001111 ("1") and o_Segment2=7'b0000001.
REQ-028 i_Score_P1 and i_Score_P2 in the same cycle from reset -> r_Score1=1 at N+1, r_Score2=1 at N+2; the next simultaneous pair grants P2 first.
REQ-029 Three P2 pulses 2 cycles apart -> o_Game_Over=1 and o_Winner=1. o_Segment2 then alternates 7'b0000110 and 7'b1111111 every 4 clocks, and o_Segment1 stays steady.
REQ-030 A P1 pulse during OVER -> o_Segment1 unchanged. A following i_Game_Reset -> both digits 7'b0000001 and o_Game_Over=0 within 2 edges.
REQ-031 Score 2-2 with P1 pending, then i_Rst_L pulsed low -> outputs show "0"/"0" immediately, and no increment occurs after release.
REQ-032 i_Game_Reset coincident with i_Score_P1 -> scores 0 and no increment.
